axi_slave_mmap_4x32_r4: RTL and testbench
=========================================

AXI_SLAVE_MMAP_4X32_R4 -- requirements
Module: axi_slave_mmap_4x32_r4

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter C_S_AXI_DATA_WIDTH SHALL default to 32: register and data-bus width (fixed at 32).
REQ-003 Parameter C_S_AXI_ADDR_WIDTH SHALL default to 4: byte address width (fixed at 4).
REQ-004 Ports SHALL be, one per line: name, direction, width, meaning.
- clock  in  1  rising-edge clock.
- reset  in  1  async active-high reset.
- S_AXI_AWADDR  in  4  write byte address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes; bit i gates WDATA[8i+7:8i].
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response, always 2'b00 (OKAY).
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  4  read byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response, always 2'b00 (OKAY).
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.

Function
REQ-005 Register map: four 32-bit registers; index = addr[3:2]; addr[1:0] ignored, so 0x0/0x4/0x8/0xC select reg0..reg3 and 0xF selects reg3.
REQ-006 Write accept: AWREADY and WREADY SHALL be registered and rise together for exactly one cycle, in the cycle after AWVALID and WVALID are both high, BVALID is low and both readies are low.
REQ-007 Write commit: in the acceptance cycle (AWVALID & AWREADY & WVALID & WREADY), each byte with its WSTRB bit set SHALL be updated from WDATA; bytes with a clear strobe bit SHALL be held.
REQ-008 BVALID SHALL assert on the clock edge following the write commit and hold until BVALID & BREADY; no new write SHALL be accepted while BVALID is high.
REQ-009 Read accept: ARREADY SHALL be registered and high for one cycle, in the cycle after ARVALID is high with RVALID low and ARREADY low.
REQ-010 On the read handshake, RDATA SHALL be loaded with reg[ARADDR[3:2]] and RVALID SHALL assert on the next edge, with both held stable until RVALID & RREADY; no new read SHALL be accepted while RVALID is high.
REQ-011 The read and write paths SHALL be independent and may run concurrently; a read that coincides with a commit to the same register SHALL return the pre-write value.
REQ-012 A master holding AWVALID/WVALID/ARVALID high for one extra cycle after its handshake SHALL NOT cause a second acceptance before the pending response completes.
REQ-013 No error responses SHALL be generated; all addresses are legal.

Reset
REQ-014 While reset is high, all four registers SHALL be 0 and AWREADY, WREADY, BVALID, ARREADY, RVALID and RDATA SHALL be 0, asynchronously.
REQ-015 Reset asserted mid-transaction SHALL abort it with no partial write; after release the block SHALL be idle and accept a new transaction.

Structure
REQ-016 A shared package SHALL hold ADDR_W=4, DATA_W=32, NUM_REGS=4, the index field [3:2] and RESP_OKAY=2'b00.
REQ-017 One sub-module, regfile_4x32_be, SHALL hold the four registers with byte-enable write and a combinational read port; the AXI handshake logic stays in the top level.

Verification
REQ-018 Release reset, read 0x0/0x4/0x8/0xC -> each returns 0x00000000 with RRESP=0.
REQ-019 Write 0xDEADBEEF/0x12345678/0xABCDEF01/0x87654321 to 0x0/0x4/0x8/0xC with WSTRB=0xF -> read-back is identical and BRESP=0.
REQ-020 Then write 0x000000FF with strb 0x1 to 0x0, 0xAA000000 with strb 0x8 to 0x4, and 0x0000FFFF with strb 0x6 to 0x8 -> reads return 0xDEADBEFF, 0xAA345678 and 0xAB00FF01.
REQ-021 Write 0xFFFFFFFF to address 0xF -> 0xC reads 0xFFFFFFFF and the other three registers are unchanged.
REQ-022 Pulse reset for 5 cycles -> all four registers read 0; then patterns 0xAAAAAAAA/0x55555555/0xFFFFFFFF/0x00000000 written to 0x0..0xC read back exactly.
REQ-023 Hold AWVALID/WVALID one cycle past the handshake with BREADY high -> exactly one AWREADY/WREADY pulse and exactly one BVALID pulse.

Source files
------------

// File: rtl/axi_slave_mmap_4x32_r4_pkg.sv
// Shared constants and helpers for the 4x32 AXI4-Lite register slave.
// Holds the address/data geometry, register index field and response code.
package axi_slave_mmap_4x32_r4_pkg;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned STRB_W   = DATA_W / 8;

    // Register index lives in the word-address bits; byte-offset bits are ignored.
    localparam int unsigned IDX_MSB = 3;
    localparam int unsigned IDX_LSB = 2;
    localparam int unsigned IDX_W   = IDX_MSB - IDX_LSB + 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [STRB_W-1:0] strb_t;

    function automatic word_t apply_strb(input word_t old_word, input word_t new_word,
                                         input strb_t strb);
        word_t merged;
        merged = old_word;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/regfile_4x32_be.sv
// Four 32-bit registers with a byte-enabled write port and a combinational read port.
// A read of the register being written in the same cycle returns the old contents.
module regfile_4x32_be
    import axi_slave_mmap_4x32_r4_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[waddr_i] = apply_strb(regs_q[waddr_i], wdata_i, wstrb_i);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/axi_slave_mmap_4x32_r4.sv
// AXI4-Lite slave exposing four 32-bit read/write registers at byte addresses 0x0..0xC.
// Independent write and read channel FSMs; register storage lives in regfile_4x32_be.
module axi_slave_mmap_4x32_r4
    import axi_slave_mmap_4x32_r4_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    // One-hot-style encodings so each handshake output is a single state flop.
    typedef enum logic [1:0] {
        StWrIdle   = 2'b00,
        StWrAccept = 2'b01,
        StWrResp   = 2'b10
    } wr_state_e;

    typedef enum logic [1:0] {
        StRdIdle   = 2'b00,
        StRdAccept = 2'b01,
        StRdResp   = 2'b10
    } rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    logic      wr_commit;
    logic      rd_load;
    word_t     rdata_q, rdata_d;
    word_t     rf_rdata;
    reg_idx_t  rf_waddr;
    reg_idx_t  rf_raddr;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[IDX_LSB-1:0], S_AXI_ARADDR[IDX_LSB-1:0]};

    assign rf_waddr = S_AXI_AWADDR[IDX_MSB:IDX_LSB];
    assign rf_raddr = S_AXI_ARADDR[IDX_MSB:IDX_LSB];

    // Write channel: readies are high only in StWrAccept, so a master that keeps
    // its valids up after the handshake finds the FSM parked in StWrResp.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_commit  = 1'b0;
        unique case (wr_state_q)
            StWrIdle: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    wr_state_d = StWrAccept;
                end
            end
            StWrAccept: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    wr_commit  = 1'b1;
                    wr_state_d = StWrResp;
                end else begin
                    wr_state_d = StWrIdle;
                end
            end
            StWrResp: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = StWrIdle;
                end
            end
            default: wr_state_d = StWrIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_state_q <= StWrIdle;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    assign S_AXI_AWREADY = (wr_state_q == StWrAccept);
    assign S_AXI_WREADY  = (wr_state_q == StWrAccept);
    assign S_AXI_BVALID  = (wr_state_q == StWrResp);
    assign S_AXI_BRESP   = RESP_OKAY;

    // Read channel: data is captured at the handshake edge and held until RREADY.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_load    = 1'b0;
        unique case (rd_state_q)
            StRdIdle: begin
                if (S_AXI_ARVALID) begin
                    rd_state_d = StRdAccept;
                end
            end
            StRdAccept: begin
                if (S_AXI_ARVALID) begin
                    rd_load    = 1'b1;
                    rd_state_d = StRdResp;
                end else begin
                    rd_state_d = StRdIdle;
                end
            end
            StRdResp: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = StRdIdle;
                end
            end
            default: rd_state_d = StRdIdle;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_load) begin
            rdata_d = rf_rdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_state_q <= StRdIdle;
            rdata_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
        end
    end

    assign S_AXI_ARREADY = (rd_state_q == StRdAccept);
    assign S_AXI_RVALID  = (rd_state_q == StRdResp);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

    regfile_4x32_be u_regfile (
        .clock   (clock),
        .reset   (reset),
        .we_i    (wr_commit),
        .waddr_i (rf_waddr),
        .wstrb_i (S_AXI_WSTRB),
        .wdata_i (S_AXI_WDATA),
        .raddr_i (rf_raddr),
        .rdata_o (rf_rdata)
    );

endmodule

// File: tb/tb_axi_slave_mmap_4x32_r4.sv
// Directed plus randomized bench for axi_slave_mmap_4x32_r4 against a word-array model.
module tb_axi_slave_mmap_4x32_r4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [3:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] mdl [4];

    always #5 clock = ~clock;

    axi_slave_mmap_4x32_r4 dut (
        .clock         (clock),
        .reset         (reset),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: word index from address bits [3:2], strobe expanded to a byte mask.
    task automatic mdl_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        logic [31:0] mask;
        int          idx;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        idx  = int'(addr) / 4;
        mdl[idx] = (mdl[idx] & ~mask) | (data & mask);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"}, {31'b0, S_AXI_AWREADY}, 32'd0);
        check({tag, "_wready"},  {31'b0, S_AXI_WREADY},  32'd0);
        check({tag, "_bvalid"},  {31'b0, S_AXI_BVALID},  32'd0);
        check({tag, "_arready"}, {31'b0, S_AXI_ARREADY}, 32'd0);
        check({tag, "_rvalid"},  {31'b0, S_AXI_RVALID},  32'd0);
        check({tag, "_rdata"},   S_AXI_RDATA,            32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        bit hs = 1'b0;
        bit bseen = 1'b0;
        S_AXI_AWADDR  = addr;
        S_AXI_AWPROT  = 3'($urandom);
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (S_AXI_AWREADY && S_AXI_WREADY) begin
                hs = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("wr_handshake", {31'b0, hs}, 32'd1);
        mdl_write(addr, data, strb);
        for (int i = 0; i < 20; i++) begin
            if (S_AXI_BVALID) begin
                bseen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("wr_bvalid", {31'b0, bseen}, 32'd1);
        check("wr_bresp", {30'b0, S_AXI_BRESP}, 32'd0);
        S_AXI_BREADY = 1'b1;
        @(posedge clock);
        #1;
        S_AXI_BREADY = 1'b0;
        check("wr_bvalid_clear", {31'b0, S_AXI_BVALID}, 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        bit hs = 1'b0;
        bit rseen = 1'b0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARPROT  = 3'($urandom);
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (S_AXI_ARREADY) begin
                hs = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        S_AXI_ARVALID = 1'b0;
        check("rd_handshake", {31'b0, hs}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (S_AXI_RVALID) begin
                rseen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("rd_rvalid", {31'b0, rseen}, 32'd1);
        check("rd_rresp", {30'b0, S_AXI_RRESP}, 32'd0);
        data = S_AXI_RDATA;
        @(posedge clock);
        #1;
        check("rd_rdata_stable", S_AXI_RDATA, data);
        check("rd_rvalid_held", {31'b0, S_AXI_RVALID}, 32'd1);
        S_AXI_RREADY = 1'b1;
        @(posedge clock);
        #1;
        S_AXI_RREADY = 1'b0;
        check("rd_rvalid_clear", {31'b0, S_AXI_RVALID}, 32'd0);
    endtask

    task automatic read_expect(input string tag, input logic [3:0] addr,
                               input logic [31:0] exp);
        logic [31:0] got;
        axi_read(addr, got);
        check(tag, got, exp);
    endtask

    initial begin
        logic [31:0] wd;
        logic [31:0] old;
        logic [31:0] got;
        logic [3:0]  a;
        logic [3:0]  s;
        int          aw_cnt, w_cnt, b_cnt, hs_i;
        bit          hs;

        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;

        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("in_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset contents
        for (int i = 0; i < 4; i++) read_expect("rst_read", 4'(i * 4), 32'h0);

        // Full-word writes
        axi_write(4'h0, 32'hDEADBEEF, 4'hF);
        axi_write(4'h4, 32'h12345678, 4'hF);
        axi_write(4'h8, 32'hABCDEF01, 4'hF);
        axi_write(4'hC, 32'h87654321, 4'hF);
        read_expect("full_r0", 4'h0, 32'hDEADBEEF);
        read_expect("full_r1", 4'h4, 32'h12345678);
        read_expect("full_r2", 4'h8, 32'hABCDEF01);
        read_expect("full_r3", 4'hC, 32'h87654321);

        // Byte strobes
        axi_write(4'h0, 32'h000000FF, 4'h1);
        axi_write(4'h4, 32'hAA000000, 4'h8);
        axi_write(4'h8, 32'h0000FFFF, 4'h6);
        read_expect("strb_r0", 4'h0, 32'hDEADBEFF);
        read_expect("strb_r1", 4'h4, 32'hAA345678);
        read_expect("strb_r2", 4'h8, 32'hAB00FF01);

        // Unaligned address 0xF selects reg3
        axi_write(4'hF, 32'hFFFFFFFF, 4'hF);
        read_expect("addrF_r3", 4'hC, 32'hFFFFFFFF);
        read_expect("addrF_r0", 4'h0, 32'hDEADBEFF);
        read_expect("addrF_r1", 4'h4, 32'hAA345678);
        read_expect("addrF_r2", 4'h8, 32'hAB00FF01);
        read_expect("addr_unaligned_rd", 4'h6, mdl[1]);

        // Valids held one cycle past the handshake with BREADY high
        wd = $urandom;
        S_AXI_AWADDR  = 4'h4;
        S_AXI_WDATA   = wd;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        aw_cnt = 0;
        w_cnt  = 0;
        b_cnt  = 0;
        hs_i   = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (S_AXI_AWREADY) aw_cnt++;
            if (S_AXI_WREADY) w_cnt++;
            if (S_AXI_BVALID) b_cnt++;
            if (S_AXI_AWREADY && S_AXI_WREADY && hs_i < 0) hs_i = i;
            @(posedge clock);
            #1;
            if (hs_i >= 0 && i == hs_i + 1) begin
                S_AXI_AWVALID = 1'b0;
                S_AXI_WVALID  = 1'b0;
            end
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        check("hold_awready_pulses", 32'(aw_cnt), 32'd1);
        check("hold_wready_pulses", 32'(w_cnt), 32'd1);
        check("hold_bvalid_pulses", 32'(b_cnt), 32'd1);
        mdl_write(4'h4, wd, 4'hF);
        read_expect("hold_r1", 4'h4, mdl[1]);

        // Read and write of the same register on the same edge
        old = mdl[2];
        wd  = $urandom;
        S_AXI_AWADDR  = 4'h8;
        S_AXI_WDATA   = wd;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = 4'h8;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (S_AXI_AWREADY && S_AXI_WREADY && S_AXI_ARREADY) begin
                hs = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        check("conc_handshake", {31'b0, hs}, 32'd1);
        check("conc_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
        check("conc_rvalid", {31'b0, S_AXI_RVALID}, 32'd1);
        check("conc_rdata_old", S_AXI_RDATA, old);
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        @(posedge clock);
        #1;
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        mdl_write(4'h8, wd, 4'hF);
        read_expect("conc_r2_new", 4'h8, mdl[2]);

        // Reset mid-write, in the acceptance cycle: no commit, outputs clear at once
        S_AXI_AWADDR  = 4'h0;
        S_AXI_WDATA   = 32'h5A5A5A5A;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (S_AXI_AWREADY && S_AXI_WREADY) begin
                hs = 1'b1;
                break;
            end
        end
        check("abort_ready_seen", {31'b0, hs}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        for (int i = 0; i < 4; i++) read_expect("post_rst_read", 4'(i * 4), 32'h0);

        axi_write(4'h0, 32'hAAAAAAAA, 4'hF);
        axi_write(4'h4, 32'h55555555, 4'hF);
        axi_write(4'h8, 32'hFFFFFFFF, 4'hF);
        axi_write(4'hC, 32'h00000000, 4'hF);
        read_expect("pat_r0", 4'h0, 32'hAAAAAAAA);
        read_expect("pat_r1", 4'h4, 32'h55555555);
        read_expect("pat_r2", 4'h8, 32'hFFFFFFFF);
        read_expect("pat_r3", 4'hC, 32'h00000000);

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            a = 4'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom;
                s  = 4'($urandom);
                axi_write(a, wd, s);
            end else begin
                axi_read(a, got);
                check($sformatf("rnd_rd_%0d_a%0h", i, a), got, mdl[int'(a) / 4]);
            end
        end
        for (int i = 0; i < 4; i++) read_expect("final_read", 4'(i * 4), mdl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
